// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
// Turns decoded PIC16C57 instruction records back into 12-bit instruction
// words and streams them into program memory at consecutive addresses.
// Used by the boot/test loader to fill program memory before the core runs.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   start           one-cycle pulse: open a new load session
//   in_valid/ready  record handshake (accept = in_valid && in_ready)
//   in_op           operation code (decoder numbering, 0 ADDWF .. 30 OPTION)
//   in_literal      k field
//   in_address      f field
//   in_d            destination bit
//   in_bit          bit number for BCF/BSF/BTFSC/BTFSS
//   pm_we           program memory write strobe, one cycle per word
//   pm_addr         write address (BASE + words already written)
//   pm_wdata        encoded word
//   count           legal words written this session
//   full            DEPTH words written; no more records accepted
//   err             sticky illegal-record flag for this session
//   checksum        XOR of every word written this session
module instr_encoder_loader #(
  parameter int                ADDR_W = 11,
  parameter int                DEPTH  = 2048,
  parameter logic [ADDR_W-1:0] BASE   = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_op,
  input  logic [8:0]        in_literal,
  input  logic [4:0]        in_address,
  input  logic              in_d,
  input  logic [2:0]        in_bit,
  output logic              pm_we,
  output logic [ADDR_W-1:0] pm_addr,
  output logic [11:0]       pm_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err,
  output logic [11:0]       checksum
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FULL = 2'd2;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [1:0]        state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [11:0]       wdata_q, wdata_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_q, err_d;
  logic [11:0]       csum_q, csum_d;

  logic [11:0] enc_word;
  logic        enc_ok;
  logic [5:0]  df;
  logic [7:0]  bf;
  logic [7:0]  k8;
  logic        accept;

  assign df = {in_d, in_address};
  assign bf = {in_bit, in_address};
  assign k8 = in_literal[7:0];

  // Encoder: inverse of the core's decode table.
  always_comb begin
    enc_word = 12'h000;
    enc_ok   = 1'b1;
    unique case (in_op)
      6'd0:  enc_word = {6'b000111, df};
      6'd1:  enc_word = 12'h000;
      6'd2:  enc_word = {6'b000101, df};
      6'd3:  enc_word = {7'b0000011, in_address};
      6'd4:  enc_word = 12'h040;
      6'd5:  enc_word = {6'b000011, df};
      6'd6:  enc_word = {6'b001011, df};
      6'd7:  enc_word = {6'b001001, df};
      6'd8:  enc_word = {6'b001010, df};
      6'd9:  enc_word = {6'b001111, df};
      6'd10: enc_word = {6'b000100, df};
      6'd11: enc_word = {6'b001000, df};
      6'd12: enc_word = {7'b0000001, in_address};
      6'd13: enc_word = {6'b001101, df};
      6'd14: enc_word = {6'b001100, df};
      6'd15: enc_word = {6'b000010, df};
      6'd16: enc_word = {6'b001110, df};
      6'd17: enc_word = {6'b000110, df};
      6'd18: enc_word = {4'b0100, bf};
      6'd19: enc_word = {4'b0101, bf};
      6'd20: enc_word = {4'b0110, bf};
      6'd21: enc_word = {4'b0111, bf};
      6'd22: enc_word = {4'b1110, k8};
      6'd23: enc_word = {4'b1001, k8};
      6'd24: enc_word = {4'b1000, k8};
      6'd25: enc_word = {3'b101, in_literal};
      6'd26: enc_word = {4'b1101, k8};
      6'd27: enc_word = {4'b1111, k8};
      6'd28: enc_word = {4'b1100, k8};
      6'd29: begin
        // TRIS only exists for ports A..C (f = 5..7)
        enc_word = {9'b0, in_address[2:0]};
        enc_ok   = (in_address[2:0] >= 3'd5);
      end
      6'd30: enc_word = 12'h002;
      default: enc_ok = 1'b0;
    endcase
  end

  assign full     = (state_q == S_FULL);
  assign in_ready = (state_q == S_RUN) && !start && !full;
  assign accept   = in_valid && in_ready;

  // start wins over everything: accept is already blocked by in_ready, so
  // only the session counters need clearing here.
  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    count_d = count_q;
    err_d   = err_q;
    csum_d  = csum_q;
    if (start) begin
      state_d = S_RUN;
      count_d = '0;
      err_d   = 1'b0;
      csum_d  = '0;
    end else if (accept) begin
      if (enc_ok) begin
        we_d    = 1'b1;
        addr_d  = BASE + count_q[ADDR_W-1:0];
        wdata_d = enc_word;
        count_d = count_q + 1'b1;
        csum_d  = csum_q ^ enc_word;
        if (count_d == DEPTH_C) state_d = S_FULL;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      addr_q  <= BASE;
      wdata_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
      err_q   <= err_d;
      csum_q  <= csum_d;
    end
  end

  assign pm_we    = we_q;
  assign pm_addr  = addr_q;
  assign pm_wdata = wdata_q;
  assign count    = count_q;
  assign err      = err_q;
  assign checksum = csum_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader. Two instances share the
// stimulus: dut_a with default parameters, dut_b with DEPTH=4, BASE=0x7FC
// for the full/no-wrap scenario. sel picks which one is being observed.
module tb_instr_encoder_loader;
  localparam int AW = 11;

  typedef struct packed {
    logic [5:0]  op;
    logic [8:0]  lit;
    logic [4:0]  f;
    logic        d;
    logic [2:0]  b;
    logic        ok;
    logic [11:0] w;
  } rec_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [11:0]   data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic [5:0] in_op = '0;
  logic [8:0] in_literal = '0;
  logic [4:0] in_address = '0;
  logic in_d = 1'b0;
  logic [2:0] in_bit = '0;
  logic sel = 1'b0;

  logic a_rdy, a_we, a_full, a_err, b_rdy, b_we, b_full, b_err;
  logic [AW-1:0] a_addr, b_addr;
  logic [11:0] a_wd, a_cs, b_wd, b_cs;
  logic [AW:0] a_cnt, b_cnt;

  logic rdy, we, full, err;
  logic [AW-1:0] addr, base;
  logic [11:0] wd, cs;
  logic [AW:0] cnt;

  assign rdy  = sel ? b_rdy  : a_rdy;
  assign we   = sel ? b_we   : a_we;
  assign full = sel ? b_full : a_full;
  assign err  = sel ? b_err  : a_err;
  assign addr = sel ? b_addr : a_addr;
  assign wd   = sel ? b_wd   : a_wd;
  assign cs   = sel ? b_cs   : a_cs;
  assign cnt  = sel ? b_cnt  : a_cnt;
  assign base = sel ? 11'h7FC : 11'h000;

  int checks = 0;
  int fails = 0;
  exp_t sbq[$];
  logic [AW:0] m_cnt;
  logic [11:0] m_sum;
  logic m_err;

  always #5 clk = ~clk;

  instr_encoder_loader dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(a_rdy),
    .in_op(in_op), .in_literal(in_literal), .in_address(in_address), .in_d(in_d),
    .in_bit(in_bit), .pm_we(a_we), .pm_addr(a_addr), .pm_wdata(a_wd), .count(a_cnt),
    .full(a_full), .err(a_err), .checksum(a_cs)
  );

  instr_encoder_loader #(.ADDR_W(AW), .DEPTH(4), .BASE(11'h7FC)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(b_rdy),
    .in_op(in_op), .in_literal(in_literal), .in_address(in_address), .in_d(in_d),
    .in_bit(in_bit), .pm_we(b_we), .pm_addr(b_addr), .pm_wdata(b_wd), .count(b_cnt),
    .full(b_full), .err(b_err), .checksum(b_cs)
  );

  function automatic rec_t mk(input logic [5:0] op, input logic [8:0] lit, input logic [4:0] f,
                              input logic d, input logic [2:0] b, input logic ok,
                              input logic [11:0] w);
    rec_t r;
    r.op = op; r.lit = lit; r.f = f; r.d = d; r.b = b; r.ok = ok; r.w = w;
    return r;
  endfunction

  task automatic drive(input rec_t r);
    in_op = r.op; in_literal = r.lit; in_address = r.f; in_d = r.d; in_bit = r.b;
  endtask

  // Record the expected effect of an accepted record in the model.
  task automatic expect_accept(input rec_t r);
    exp_t e;
    if (r.ok) begin
      e.addr = base + m_cnt[AW-1:0];
      e.data = r.w;
      sbq.push_back(e);
      m_cnt = m_cnt + 1'b1;
      m_sum = m_sum ^ r.w;
    end else begin
      m_err = 1'b1;
    end
  endtask

  // Entered and left just after a falling edge.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_cnt = '0; m_sum = '0; m_err = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({a_we, a_rdy, a_full, a_err} !== 4'b0 || a_addr !== 11'h000 || a_wd !== 12'h0 ||
        a_cnt !== '0 || a_cs !== 12'h0) begin
      fails++;
      $display("FAIL reset_a: we=%b rdy=%b full=%b err=%b addr=%h wd=%h cnt=%0d cs=%h, want all zero",
               a_we, a_rdy, a_full, a_err, a_addr, a_wd, a_cnt, a_cs);
    end
    checks++;
    if (b_addr !== 11'h7FC || b_we !== 1'b0 || b_rdy !== 1'b0) begin
      fails++;
      $display("FAIL reset_b: addr=%h we=%b rdy=%b, want addr=7fc we=0 rdy=0", b_addr, b_we, b_rdy);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (a_rdy !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle_ready: got %b want 0", a_rdy);
    end
  endtask

  task automatic test_back_to_back();
    rec_t t[$];
    exp_t e;
    int idx = 0;
    t.push_back(mk(6'd0,  9'h000, 5'h0A, 1'b1, 3'd0, 1'b1, 12'h1EA));
    t.push_back(mk(6'd25, 9'h155, 5'h00, 1'b0, 3'd0, 1'b1, 12'hB55));
    t.push_back(mk(6'd19, 9'h000, 5'h03, 1'b0, 3'd3, 1'b1, 12'h563));
    t.push_back(mk(6'd28, 9'h0A5, 5'h00, 1'b0, 3'd0, 1'b1, 12'hCA5));
    t.push_back(mk(6'd3,  9'h000, 5'h1F, 1'b0, 3'd0, 1'b1, 12'h07F));
    t.push_back(mk(6'd12, 9'h000, 5'h05, 1'b1, 3'd0, 1'b1, 12'h025));
    t.push_back(mk(6'd4,  9'h000, 5'h00, 1'b0, 3'd0, 1'b1, 12'h040));
    t.push_back(mk(6'd30, 9'h000, 5'h00, 1'b0, 3'd0, 1'b1, 12'h002));
    t.push_back(mk(6'd23, 9'h13C, 5'h00, 1'b0, 3'd0, 1'b1, 12'h93C));
    t.push_back(mk(6'd24, 9'h1FF, 5'h00, 1'b0, 3'd0, 1'b1, 12'h8FF));
    t.push_back(mk(6'd21, 9'h000, 5'h10, 1'b0, 3'd7, 1'b1, 12'h7F0));
    t.push_back(mk(6'd16, 9'h000, 5'h1F, 1'b0, 3'd0, 1'b1, 12'h39F));
    t.push_back(mk(6'd15, 9'h000, 5'h01, 1'b1, 3'd0, 1'b1, 12'h0A1));
    t.push_back(mk(6'd29, 9'h000, 5'h1D, 1'b0, 3'd0, 1'b1, 12'h005));
    t.push_back(mk(6'd27, 9'h05A, 5'h00, 1'b0, 3'd0, 1'b1, 12'hF5A));
    t.push_back(mk(6'd6,  9'h000, 5'h15, 1'b0, 3'd0, 1'b1, 12'h2D5));
    t.push_back(mk(6'd18, 9'h000, 5'h1F, 1'b0, 3'd0, 1'b1, 12'h41F));
    t.push_back(mk(6'd22, 9'h00F, 5'h00, 1'b0, 3'd0, 1'b1, 12'hE0F));
    sel = 1'b0;
    pulse_start();
    for (int cyc = 0; cyc < t.size() + 2; cyc++) begin
      in_valid = (idx < t.size());
      if (in_valid) drive(t[idx]);
      #1;
      if (in_valid) begin
        checks++;
        if (rdy !== 1'b1) begin
          fails++;
          $display("FAIL b2b_ready rec %0d: got %b want 1", idx, rdy);
        end
        if (rdy) begin expect_accept(t[idx]); idx++; end
      end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (we !== (sbq.size() != 0)) begin
        fails++;
        $display("FAIL b2b_we cyc %0d: got %b want %b", cyc, we, sbq.size() != 0);
      end
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        checks++;
        if (addr !== e.addr || wd !== e.data) begin
          fails++;
          $display("FAIL b2b_word cyc %0d: got addr=%h data=%h want addr=%h data=%h",
                   cyc, addr, wd, e.addr, e.data);
        end
      end
      checks++;
      if (cnt !== m_cnt || cs !== m_sum || err !== m_err) begin
        fails++;
        $display("FAIL b2b_state cyc %0d: got cnt=%0d cs=%h err=%b want cnt=%0d cs=%h err=%b",
                 cyc, cnt, cs, err, m_cnt, m_sum, m_err);
      end
    end
    checks++;
    if (addr !== 11'd17 || wd !== 12'hE0F) begin
      fails++;
      $display("FAIL b2b_hold: got addr=%h data=%h want addr=011 data=e0f", addr, wd);
    end
  endtask

  task automatic test_illegal();
    rec_t t[$];
    exp_t e;
    int idx = 0;
    t.push_back(mk(6'd40, 9'h0FF, 5'h1F, 1'b1, 3'd7, 1'b0, 12'h000));
    t.push_back(mk(6'd29, 9'h000, 5'h04, 1'b0, 3'd0, 1'b0, 12'h000));
    t.push_back(mk(6'd29, 9'h000, 5'h06, 1'b0, 3'd0, 1'b1, 12'h006));
    sel = 1'b0;
    pulse_start();
    for (int cyc = 0; cyc < t.size() + 2; cyc++) begin
      in_valid = (idx < t.size());
      if (in_valid) drive(t[idx]);
      #1;
      if (in_valid && rdy) begin expect_accept(t[idx]); idx++; end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (we !== (sbq.size() != 0)) begin
        fails++;
        $display("FAIL illegal_we cyc %0d: got %b want %b", cyc, we, sbq.size() != 0);
      end
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        checks++;
        if (addr !== e.addr || wd !== e.data) begin
          fails++;
          $display("FAIL illegal_word cyc %0d: got addr=%h data=%h want addr=%h data=%h",
                   cyc, addr, wd, e.addr, e.data);
        end
      end
      checks++;
      if (cnt !== m_cnt || cs !== m_sum || err !== m_err) begin
        fails++;
        $display("FAIL illegal_state cyc %0d: got cnt=%0d cs=%h err=%b want cnt=%0d cs=%h err=%b",
                 cyc, cnt, cs, err, m_cnt, m_sum, m_err);
      end
    end
    checks++;
    if (idx != 3) begin
      fails++;
      $display("FAIL illegal_consumed: got %0d want 3", idx);
    end
  endtask

  task automatic test_full();
    rec_t t[$];
    exp_t e;
    int idx = 0;
    logic exp_rdy;
    for (int i = 0; i < 5; i++) t.push_back(mk(6'd1, 9'(i * 37), 5'(i * 7), 1'b1, 3'(i), 1'b1, 12'h000));
    sel = 1'b1;
    pulse_start();
    for (int cyc = 0; cyc < 10; cyc++) begin
      start = (cyc == 7);
      in_valid = (idx < t.size());
      if (in_valid) drive(t[idx]);
      #1;
      exp_rdy = (cyc < 4) || (cyc >= 8);
      if (in_valid) begin
        checks++;
        if (rdy !== exp_rdy) begin
          fails++;
          $display("FAIL full_ready cyc %0d: got %b want %b", cyc, rdy, exp_rdy);
        end
        if (rdy) begin expect_accept(t[idx]); idx++; end
      end
      if (cyc == 6) begin
        checks++;
        if (full !== 1'b1 || idx != 4 || addr !== 11'h7FF) begin
          fails++;
          $display("FAIL full_flag: got full=%b accepted=%0d addr=%h want full=1 accepted=4 addr=7ff",
                   full, idx, addr);
        end
      end
      if (cyc == 7) begin m_cnt = '0; m_sum = '0; m_err = 1'b0; end
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (we !== (sbq.size() != 0)) begin
        fails++;
        $display("FAIL full_we cyc %0d: got %b want %b", cyc, we, sbq.size() != 0);
      end
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        checks++;
        if (addr !== e.addr || wd !== e.data) begin
          fails++;
          $display("FAIL full_word cyc %0d: got addr=%h data=%h want addr=%h data=%h",
                   cyc, addr, wd, e.addr, e.data);
        end
      end
      checks++;
      if (cnt !== m_cnt || cs !== m_sum || full !== (cyc >= 3 && cyc < 7)) begin
        fails++;
        $display("FAIL full_state cyc %0d: got cnt=%0d cs=%h full=%b want cnt=%0d cs=%h full=%b",
                 cyc, cnt, cs, full, m_cnt, m_sum, (cyc >= 3 && cyc < 7));
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_start_collision();
    rec_t r;
    r = mk(6'd28, 9'h03C, 5'h00, 1'b0, 3'd0, 1'b1, 12'hC3C);
    sel = 1'b0;
    drive(r);
    in_valid = 1'b1;
    start = 1'b1;
    #1;
    checks++;
    if (rdy !== 1'b0) begin
      fails++;
      $display("FAIL collide_ready: got %b want 0", rdy);
    end
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    m_cnt = '0; m_sum = '0; m_err = 1'b0;
    checks++;
    if (we !== 1'b0 || cnt !== '0 || cs !== 12'h0 || err !== 1'b0) begin
      fails++;
      $display("FAIL collide_clear: got we=%b cnt=%0d cs=%h err=%b want 0 0 000 0", we, cnt, cs, err);
    end
    #1;
    checks++;
    if (rdy !== 1'b1) begin
      fails++;
      $display("FAIL collide_ready_next: got %b want 1", rdy);
    end
    if (rdy) expect_accept(r);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (sbq.size() != 1 || we !== 1'b1) begin
      fails++;
      $display("FAIL collide_we: got we=%b queued=%0d want we=1 queued=1", we, sbq.size());
    end else begin
      exp_t e;
      e = sbq.pop_front();
      checks++;
      if (addr !== e.addr || wd !== e.data || cnt !== m_cnt || cs !== m_sum) begin
        fails++;
        $display("FAIL collide_word: got addr=%h data=%h cnt=%0d cs=%h want addr=%h data=%h cnt=%0d cs=%h",
                 addr, wd, cnt, cs, e.addr, e.data, m_cnt, m_sum);
      end
    end
    sbq.delete();
  endtask

  task automatic test_reset_mid();
    sel = 1'b0;
    pulse_start();
    drive(mk(6'd0, 9'h000, 5'h0A, 1'b1, 3'd0, 1'b1, 12'h1EA));
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({a_we, a_rdy, a_full, a_err} !== 4'b0 || a_addr !== 11'h000 || a_wd !== 12'h0 ||
        a_cnt !== '0 || a_cs !== 12'h0 || b_addr !== 11'h7FC) begin
      fails++;
      $display("FAIL midreset_outputs: we=%b rdy=%b full=%b err=%b addr=%h wd=%h cnt=%0d cs=%h b_addr=%h",
               a_we, a_rdy, a_full, a_err, a_addr, a_wd, a_cnt, a_cs, b_addr);
    end
    rst_n = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (a_rdy !== 1'b0 || a_we !== 1'b0) begin
        fails++;
        $display("FAIL midreset_idle %0d: got rdy=%b we=%b want 0 0", i, a_rdy, a_we);
      end
    end
    in_valid = 1'b0;
    pulse_start();
    #1;
    checks++;
    if (a_rdy !== 1'b1) begin
      fails++;
      $display("FAIL midreset_restart: got rdy=%b want 1", a_rdy);
    end
  endtask

  initial begin
    m_cnt = '0; m_sum = '0; m_err = 1'b0;
    test_reset();
    test_back_to_back();
    test_illegal();
    test_full();
    test_start_collision();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the core's instruction decoder: takes decoded-form instruction records (operation code plus literal/address/d/bit fields), encodes each into a 12-bit PIC16C57 instruction word, and writes it into program memory sequentially.
- Used by the boot/test loader to fill program memory before the core is released from reset.
- One-entry output register, valid/ready input handshake, address counter, full detection, sticky illegal-op flag and running XOR checksum.

Parameters:
- ADDR_W, 11, program memory address width (2K words).
- DEPTH, 2048, number of words writable per load session (1..2^ADDR_W).
- BASE, 0, first program memory address written after start.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse that opens a new load session.
- in_valid  input  1  instruction record present.
- in_ready  output  1  block accepts the record this cycle.
- in_op  input  6  operation code, same numbering as the decoder (0 ADDWF … 30 OPTION).
- in_literal  input  9  k field.
- in_address  input  5  f field.
- in_d  input  1  destination bit.
- in_bit  input  3  bit number for BCF/BSF/BTFSC/BTFSS.
- pm_we  output  1  program memory write strobe, one cycle per word.
- pm_addr  output  ADDR_W  write address.
- pm_wdata  output  12  encoded instruction.
- count  output  ADDR_W+1  legal words written this session.
- full  output  1  DEPTH words written.
- err  output  1  sticky: an illegal record was seen this session.
- checksum  output  12  XOR of all words written this session.

Behaviour:
- Reset (async, rst_n=0): state IDLE. pm_we=0, pm_addr=BASE, pm_wdata=0, count=0, full=0, err=0, checksum=0, in_ready=0.
- States:
  - IDLE: entered from reset. start goes to RUN.
  - RUN: go to FULL when count reaches DEPTH.
  - FULL: start goes to RUN.
  - start in any state clears count, err and checksum and enters RUN next cycle.
- Handshake:
  - in_ready = (state==RUN) && !start && !full. This is combinational from registered state.
  - Accept = in_valid && in_ready. Records can be accepted back-to-back, one per cycle.
- Latency:
  - A legal record accepted at edge N gives pm_we=1 in cycle N+1, with pm_addr=BASE+count_old and pm_wdata=encoded word.
  - count increments and checksum ^= word, both visible at N+1.
  - pm_we is 0 in every other cycle. pm_addr/pm_wdata hold their last values.
- Encoding: "df" = {in_d, in_address}; "bf" = {in_bit, in_address}; "k8" = in_literal[7:0].
  - op 0 ADDWF: 000111 df.
  - op 2 ANDWF: 000101 df.
  - op 5 DECF: 000011 df.
  - op 6 DECFSZ: 001011 df.
  - op 7 COMF: 001001 df.
  - op 8 INCF: 001010 df.
  - op 9 INCFSZ: 001111 df.
  - op 10 IORWF: 000100 df.
  - op 11 MOVF: 001000 df.
  - op 13 RLF: 001101 df.
  - op 14 RRF: 001100 df.
  - op 15 SUBWF: 000010 df.
  - op 16 SWAPF: 001110 df.
  - op 17 XORWF: 000110 df.
  - op 1 OTHERS (NOP): 000000000000.
  - op 3 CLRF: 0000011 in_address.
  - op 4 CLRW: 000001000000.
  - op 12 MOVWF: 0000001 in_address.
  - op 18 BCF: 0100 bf.
  - op 19 BSF: 0101 bf.
  - op 20 BTFSC: 0110 bf.
  - op 21 BTFSS: 0111 bf.
  - op 22 ANDWL: 1110 k8.
  - op 23 CALL: 1001 k8.
  - op 24 RETLW: 1000 k8.
  - op 26 IORLW: 1101 k8.
  - op 27 XORLW: 1111 k8.
  - op 28 MOVLW: 1100 k8.
  - op 25 GOTO: 101 in_literal[8:0].
  - op 29 TRIS: 000000000 in_address[2:0].
  - op 30 OPTION: 000000000010.
- Illegal records:
  - Any op 31..63.
  - TRIS with in_address[2:0] not in 5..7.
  - Handling: the record is accepted (consumed), err is set, no write, count and checksum unchanged.
- Full:
  - full=1 from the cycle after the DEPTH-th write. in_ready=0 from then on.
  - pm_addr never exceeds BASE+DEPTH-1. There is no wrap-around.
- Simultaneous events:
  - start with in_valid: the record is not accepted (in_ready=0), so the source holds it.
  - A write scheduled for the start cycle's edge still completes before the counters clear.
- Reset mid-session: everything returns to reset values immediately. A pending pm_we is dropped.

Test Plan:
1. Reset, start, then ADDWF with d=1, f=0x0A → pm_we one cycle later, pm_addr=0, pm_wdata=0x1EA, count=1, checksum=0x1EA.
2. Back-to-back GOTO k=0x155, BSF bit=3 f=0x03, MOVLW k=0xA5 → three consecutive pm_we cycles, addr 0,1,2, data 0xB55, 0x563, 0xCA5, in_ready high throughout.
3. Illegal op 40, then TRIS f=0x04, then TRIS f=0x06 → err=1 after the first record, no write for the first two, then one write 0x006 at addr 0, count=1.
4. DEPTH=4, BASE=0x7FC, five NOP records offered → writes at 0x7FC..0x7FF, full=1, in_ready=0, fifth record stays pending. Then start → full=0, count=0, fifth record accepted at 0x7FC.
5. start asserted in the same cycle as in_valid → no accept. Record accepted the next cycle at addr BASE.
6. rst_n low for one cycle right after a record is accepted → no pm_we, all outputs at reset values, state IDLE, in_ready=0 until start.
